// File: rtl/rs_chien_forney_eval.sv
// -----------------------------------------------------------------------------
// rs_chien_forney_eval
// Sequential Chien search plus Forney error evaluator for Reed-Solomon codes
// over GF(2^4). One Lambda/Omega pair is loaded per codeword; one error value
// is then streamed per codeword position, highest position (first received
// symbol) first, with ready/valid backpressure and a decode-failure verdict
// on the final beat.
//
// Ports:
//   CLK        : clock, all state changes on the rising edge
//   RESET      : synchronous active-high reset
//   START      : load request, accepted only while READY=1
//   LAMBDA     : error locator, Lambda_i at [4i+3:4i], Lambda_0 in the LSBs
//   OMEGA      : error evaluator, Omega_i at [4i+3:4i]
//   READY      : idle, START will be accepted
//   OUT_VALID  : an output beat is present
//   OUT_READY  : downstream accepts the current beat
//   ERR_VALUE  : error magnitude for the current position (0 if no error)
//   ERR_FLAG   : current position is an error location
//   OUT_LAST   : final beat (position 0)
//   NUM_ERRORS : number of roots found, non-zero only on the OUT_LAST beat
//   FAIL       : uncorrectable verdict, only on the OUT_LAST beat
// -----------------------------------------------------------------------------
module rs_chien_forney_eval #(
  parameter int         T         = 2,
  parameter int         N         = 15,
  parameter logic [4:0] PRIM_POLY = 5'h13,
  parameter int         CNT_W     = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic [4*(T+1)-1:0] LAMBDA,
  input  logic [4*T-1:0]     OMEGA,
  output logic               READY,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [3:0]         ERR_VALUE,
  output logic               ERR_FLAG,
  output logic               OUT_LAST,
  output logic [CNT_W-1:0]   NUM_ERRORS,
  output logic               FAIL
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // GF(16) multiply, shift-and-add reduced by PRIM_POLY.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = 4'h0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      acc = acc ^ (b[i] ? sh : 4'h0);
      sh  = sh[3] ? ({sh[2:0], 1'b0} ^ PRIM_POLY[3:0]) : {sh[2:0], 1'b0};
    end
    return acc;
  endfunction

  // alpha^e with alpha = x; exponent taken mod 15 (multiplicative order).
  function automatic logic [3:0] gf_alpha_pow(input int e);
    logic [3:0] r;
    int         em;
    r  = 4'h1;
    em = e % 15;
    for (int i = 0; i < 14; i++) begin
      r = (i < em) ? gf_mul(r, 4'h2) : r;
    end
    return r;
  endfunction

  // Inverse as a^14 = a^2 * a^4 * a^8; a=0 naturally yields 0.
  function automatic logic [3:0] gf_inv(input logic [3:0] a);
    logic [3:0] a2;
    logic [3:0] a4;
    logic [3:0] a8;
    a2 = gf_mul(a, a);
    a4 = gf_mul(a2, a2);
    a8 = gf_mul(a4, a4);
    return gf_mul(gf_mul(a2, a4), a8);
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;

  logic [3:0]       lam_r      [0:T];
  logic [3:0]       omg_r      [0:T-1];
  logic [3:0]       lam_load_s [0:T];
  logic [3:0]       omg_load_s [0:T-1];
  logic [3:0]       lam_step_s [0:T];
  logic [3:0]       omg_step_s [0:T-1];

  logic [CNT_W-1:0] k_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] deg_r;
  logic             latch_r;
  logic             lam0_zero_r;

  logic             ready_r;
  logic             out_valid_r;
  logic [3:0]       err_value_r;
  logic             err_flag_r;
  logic             out_last_r;
  logic [CNT_W-1:0] num_r;
  logic             fail_r;

  logic [CNT_W-1:0] deg_s;
  logic [3:0]       l_s;
  logic [3:0]       d_s;
  logic [3:0]       w_s;
  logic             flag_s;
  logic             root_fail_s;
  logic [3:0]       val_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             last_s;
  logic             fail_s;
  logic             load_s;
  logic             xfer_s;

  // Coefficient load values (pre-scaled so beat 0 evaluates position N-1)
  // and the per-beat step (Lambda_i and Omega_i advance by alpha^i).
  always_comb begin
    for (int i = 0; i <= T; i++) begin
      lam_load_s[i] = gf_mul(LAMBDA[4*i +: 4], gf_alpha_pow(i * (16 - N)));
      lam_step_s[i] = gf_mul(lam_r[i], gf_alpha_pow(i));
    end
    for (int i = 0; i < T; i++) begin
      omg_load_s[i] = gf_mul(OMEGA[4*i +: 4], gf_alpha_pow(i * (16 - N)));
      omg_step_s[i] = gf_mul(omg_r[i], gf_alpha_pow(i));
    end
  end

  // Degree of the incoming Lambda: highest index with a nonzero coefficient.
  always_comb begin
    deg_s = {CNT_W{1'b0}};
    for (int i = 1; i <= T; i++) begin
      deg_s = (LAMBDA[4*i +: 4] != 4'h0) ? CNT_W'(i) : deg_s;
    end
  end

  // Evaluate Lambda, its odd part (x * Lambda'(x)) and Omega at this beat.
  always_comb begin
    l_s = 4'h0;
    d_s = 4'h0;
    w_s = 4'h0;
    for (int i = 0; i <= T; i++) begin
      l_s = l_s ^ lam_r[i];
      d_s = d_s ^ (((i % 2) == 1) ? lam_r[i] : 4'h0);
    end
    for (int i = 0; i < T; i++) begin
      w_s = w_s ^ omg_r[i];
    end
  end

  // Forney value, root accounting and final verdict for the beat being formed.
  always_comb begin
    flag_s      = (l_s == 4'h0);
    root_fail_s = flag_s && (d_s == 4'h0);
    if (flag_s && !root_fail_s) begin
      val_s = gf_mul(w_s, gf_inv(d_s));
    end else begin
      val_s = 4'h0;
    end
    cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, flag_s};
    last_s    = (k_r == CNT_W'(N - 1));
    fail_s    = lam0_zero_r | latch_r | root_fail_s | (cnt_nxt_s != deg_r);
    // A new beat may be formed when the output slot is empty or draining now.
    load_s    = (state_r == SCAN) && (!out_valid_r || OUT_READY);
    xfer_s    = out_valid_r && OUT_READY;
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; DRAIN is entered as the last beat is formed.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = START ? SCAN : IDLE;
      SCAN:    state_nxt_s = (load_s && last_s) ? DRAIN : SCAN;
      DRAIN:   state_nxt_s = xfer_s ? IDLE : DRAIN;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath: coefficient registers, counters and the registered output beat.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i <= T; i++) lam_r[i] <= 4'h0;
      for (int i = 0; i < T; i++)  omg_r[i] <= 4'h0;
      k_r         <= {CNT_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      deg_r       <= {CNT_W{1'b0}};
      latch_r     <= 1'b0;
      lam0_zero_r <= 1'b0;
      ready_r     <= 1'b1;
      out_valid_r <= 1'b0;
      err_value_r <= 4'h0;
      err_flag_r  <= 1'b0;
      out_last_r  <= 1'b0;
      num_r       <= {CNT_W{1'b0}};
      fail_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (START) begin
            for (int i = 0; i <= T; i++) lam_r[i] <= lam_load_s[i];
            for (int i = 0; i < T; i++)  omg_r[i] <= omg_load_s[i];
            k_r         <= {CNT_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            latch_r     <= 1'b0;
            deg_r       <= deg_s;
            lam0_zero_r <= (LAMBDA[3:0] == 4'h0);
            ready_r     <= 1'b0;
          end
        end
        SCAN: begin
          if (load_s) begin
            for (int i = 0; i <= T; i++) lam_r[i] <= lam_step_s[i];
            for (int i = 0; i < T; i++)  omg_r[i] <= omg_step_s[i];
            k_r         <= k_r + {{(CNT_W-1){1'b0}}, 1'b1};
            cnt_r       <= cnt_nxt_s;
            latch_r     <= latch_r | root_fail_s;
            out_valid_r <= 1'b1;
            err_value_r <= val_s;
            err_flag_r  <= flag_s;
            out_last_r  <= last_s;
            num_r       <= last_s ? cnt_nxt_s : {CNT_W{1'b0}};
            fail_r      <= last_s ? fail_s : 1'b0;
          end
        end
        DRAIN: begin
          if (xfer_s) begin
            out_valid_r <= 1'b0;
            err_value_r <= 4'h0;
            err_flag_r  <= 1'b0;
            out_last_r  <= 1'b0;
            num_r       <= {CNT_W{1'b0}};
            fail_r      <= 1'b0;
            ready_r     <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          ready_r     <= 1'b1;
        end
      endcase
    end
  end

  assign READY      = ready_r;
  assign OUT_VALID  = out_valid_r;
  assign ERR_VALUE  = err_value_r;
  assign ERR_FLAG   = err_flag_r;
  assign OUT_LAST   = out_last_r;
  assign NUM_ERRORS = num_r;
  assign FAIL       = fail_r;

endmodule

// File: doc/rs_chien_forney_eval.md
Name: rs_chien_forney_eval

Overview:
- Parametrised sequential Chien search and Forney error evaluator for Reed-Solomon codes over GF(2^4).
- Sits between the key-equation solver and the correction adder in the RS decoder.
- Accepts one error-locator polynomial Lambda(x) and one error-evaluator polynomial Omega(x) per codeword.
- Streams one error value per codeword position, first-received symbol first, with output backpressure and a decode-failure verdict.

Parameters:
- T, 2, correction capability. Lambda has T+1 coefficients; Omega has T coefficients. Legal range 1..4.
- N, 15, codeword length in symbols. Legal range 2T+1..15; values below 15 give a shortened code.
- PRIM_POLY, 5'h13, field primitive polynomial (x^4+x+1); alpha = 4'h2.
- CNT_W, 4, width of the position counter and of NUM_ERRORS.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  load request; accepted only when READY=1.
- LAMBDA  in  4*(T+1)  Lambda_i occupies bits [4i+3:4i]; Lambda_0 in the LSBs.
- OMEGA  in  4*T  Omega_i occupies bits [4i+3:4i].
- READY  out  1  block is idle and can accept START.
- OUT_VALID  out  1  an output beat is present.
- OUT_READY  in  1  downstream accepts the beat.
- ERR_VALUE  out  4  error magnitude for the current position; 0 when there is no error.
- ERR_FLAG  out  1  the current position is an error location.
- OUT_LAST  out  1  marks the final beat (position 0).
- NUM_ERRORS  out  CNT_W  count of roots found; valid on the OUT_LAST beat.
- FAIL  out  1  uncorrectable verdict; valid on the OUT_LAST beat.

Behaviour:
- Reset values: READY=1 and every other output 0. All internal registers clear; state=IDLE.
- FSM states are IDLE, SCAN and DRAIN.
- IDLE → SCAN when START=1 at an edge:
  - Register i loads Lambda_i·alpha^(i·(16-N)).
  - Omega register i loads Omega_i·alpha^(i·(16-N)).
  - Position counter k=0, root count=0, failure latch=0; READY drops.
- Beat k evaluates at x = alpha^-(N-1-k), which is codeword position p = N-1-k. The first OUT_VALID is asserted after the edge following the START edge (one-cycle latency).
- Each advance multiplies Lambda register i and Omega register i by alpha^i. No register changes while the stall condition holds.
- Per beat (combinational, then registered):
  - L = XOR of all Lambda registers.
  - D = XOR of the odd-index Lambda registers.
  - W = XOR of the Omega registers.
  - ERR_FLAG = (L==0).
  - ERR_VALUE = ERR_FLAG ? W·inv(D) : 0.
  - If ERR_FLAG=1 and D==0: ERR_VALUE=0 and the failure latch is set.
- Stall: while OUT_VALID=1 and OUT_READY=0, all outputs and internal state hold.
- Advance: a beat transfers when OUT_VALID=1 and OUT_READY=1.
  - The root count increments on a transfer with ERR_FLAG=1.
  - The beat for k=N-1 carries OUT_LAST=1. Entering that beat moves the FSM to DRAIN.
- DRAIN → IDLE on transfer of the last beat; OUT_VALID drops and READY rises on the next cycle.
- NUM_ERRORS and FAIL are driven on the OUT_LAST beat and read 0 otherwise.
- NUM_ERRORS = roots found, including the root on the last beat.
- FAIL=1 when any of the following holds:
  - Lambda_0==0;
  - NUM_ERRORS ≠ deg(Lambda), where deg is the highest index with a nonzero coefficient;
  - the failure latch is set.
- Lambda==1 (degree 0) gives no errors, NUM_ERRORS=0 and FAIL=0.
- START while READY=0 is ignored, with no effect on the current scan.
- RESET at any point aborts the scan. Outputs return to reset values at the next edge; any partial stream is discarded.
- GF multiply is mod PRIM_POLY. inv(0) is defined as 0.

Test Plan:
- Single error: T=2, N=15, LAMBDA={0,8,1} (Lambda_1=alpha^3), OMEGA={0,5}, OUT_READY=1 → 15 beats; only beat k=11 (p=3) has ERR_FLAG=1, ERR_VALUE=5; last beat NUM_ERRORS=1, FAIL=0; first OUT_VALID one cycle after START.
- No error: LAMBDA={0,0,1}, OMEGA={0,9} → 15 beats, all ERR_VALUE=0; NUM_ERRORS=0, FAIL=0; READY reasserts one cycle after the OUT_LAST transfer.
- Failure: LAMBDA={0,1,0} (Lambda_0=0) → FAIL=1 on OUT_LAST. Separately, parameter N=11 with LAMBDA={0,F,1} (root at p=12, outside the scanned range) → NUM_ERRORS=0, FAIL=1.
- Backpressure: repeat the single-error case with OUT_READY low for 3 cycles during beat k=11 → ERR_VALUE=5 and ERR_FLAG held stable; the stream is identical to the unstalled run; NUM_ERRORS=1.
- START during a scan, then RESET: START pulse at k=5 → ignored, stream unchanged. RESET at k=7 → next cycle READY=1 and OUT_VALID=0; a new START yields a clean 15-beat stream.
- Random regression: 500 random Lambda/Omega pairs checked against a software GF(16) model of the same formula, T=2 and T=4, with random OUT_READY gaps.
